sram_port_arbiter: RTL and testbench

Shares one synchronous single-port SRAM between the instruction-fetch requester (IF stage) and the data requester (EX/MEM stages) of the 5-stage CPU. It replaces the separate inst/data SRAM ports at the CPU top with a request/addr_ok/data_ok handshake per requester. It issues at most one SRAM access per cycle, tracks the single outstanding access, buffers the read data when the owner is not ready, and prevents fetch starvation.

---
 rtl/sram_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous single-port SRAM between the
// instruction-fetch requester and the data requester. It issues at most one
// access per cycle, tracks the single outstanding access, parks unaccepted
// read data in a hold register and forces a fetch grant after the fetch
// side has lost STARVE_MAX contested cycles in a row.
module sram_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction-fetch requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_rready,
  // data requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        data_rready,
  // SRAM port
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no outstanding access
    S_WAIT = 2'd1,  // access issued last cycle, sram_rdata valid now
    S_HOLD = 2'd2   // response parked in hold_q, not yet accepted
  } state_e;

  typedef enum logic [1:0] {
    O_NONE = 2'd0,
    O_INST = 2'd1,
    O_DRD  = 2'd2,
    O_DWR  = 2'd3
  } owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [31:0]   hold_q, hold_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          resp_inst_s;
  logic          resp_data_s;
  logic [31:0]   resp_rdata_s;
  logic          complete_s;
  logic          free_s;
  logic          inst_win_s;
  logic          data_win_s;
  logic          grant_s;
  owner_e        grant_owner_s;

  // Response ownership, completion and the grant decision for this cycle.
  always_comb begin
    resp_inst_s   = (state_q != S_IDLE) && (owner_q == O_INST);
    resp_data_s   = (state_q != S_IDLE) && ((owner_q == O_DRD) || (owner_q == O_DWR));
    resp_rdata_s  = (state_q == S_WAIT) ? sram_rdata : hold_q;
    complete_s    = (resp_inst_s && inst_rready) || (resp_data_s && data_rready);
    // A new access may go out when nothing is pending, or when the pending
    // response retires this very cycle (back-to-back throughput).
    free_s        = (state_q == S_IDLE) || complete_s;
    // Data wins contested cycles unless fetch has starved long enough.
    inst_win_s    = free_s && inst_req && (!data_req || (starve_q == STARVE_MAX_C));
    data_win_s    = free_s && data_req && !inst_win_s;
    grant_s       = inst_win_s || data_win_s;
    if (inst_win_s) begin
      grant_owner_s = O_INST;
    end else if (data_wr) begin
      grant_owner_s = O_DWR;
    end else begin
      grant_owner_s = O_DRD;
    end
  end

  // Request-side outputs and SRAM drive; all forced low while in reset.
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    sram_en      = 1'b0;
    sram_we      = 4'b0000;
    sram_addr    = 32'h0000_0000;
    sram_wdata   = 32'h0000_0000;
    if (!resetn) begin
      sram_en = 1'b0;
    end else if (data_win_s) begin
      data_addr_ok = 1'b1;
      sram_en      = 1'b1;
      sram_we      = data_wr ? data_wstrb : 4'b0000;
      sram_addr    = data_addr;
      sram_wdata   = data_wdata;
    end else if (inst_win_s) begin
      inst_addr_ok = 1'b1;
      sram_en      = 1'b1;
      sram_addr    = inst_addr;
    end else begin
      sram_en = 1'b0;
    end
  end

  // Response-side outputs; rdata is zero unless a read response is valid.
  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0000_0000;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0000_0000;
    if (!resetn) begin
      inst_data_ok = 1'b0;
    end else begin
      inst_data_ok = resp_inst_s;
      data_data_ok = resp_data_s;
      if (resp_inst_s) begin
        inst_rdata = resp_rdata_s;
      end else begin
        inst_rdata = 32'h0000_0000;
      end
      if (resp_data_s && (owner_q == O_DRD)) begin
        data_rdata = resp_rdata_s;
      end else begin
        data_rdata = 32'h0000_0000;
      end
    end
  end

  // Next state, response owner and hold register.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          state_d = S_WAIT;
          owner_d = grant_owner_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (complete_s && grant_s) begin
          state_d = S_WAIT;
          owner_d = grant_owner_s;
        end else if (complete_s) begin
          state_d = S_IDLE;
          owner_d = O_NONE;
        end else begin
          // Owner not ready: park the read data, it is gone next cycle.
          state_d = S_HOLD;
          hold_d  = sram_rdata;
        end
      end
      S_HOLD: begin
        if (complete_s && grant_s) begin
          state_d = S_WAIT;
          owner_d = grant_owner_s;
        end else if (complete_s) begin
          state_d = S_IDLE;
          owner_d = O_NONE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = O_NONE;
      end
    endcase
  end

  // Fetch starvation counter: counts data wins while fetch waits, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!inst_req || inst_win_s) begin
      starve_d = '0;
    end else if (data_win_s && (starve_q != STARVE_MAX_C)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers; reset discards any outstanding response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      owner_q  <= O_NONE;
      hold_q   <= 32'h0000_0000;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM model.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_rready, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_rready, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // backdoor preload port into the SRAM model
  logic        bd_en;
  logic [31:0] bd_addr, bd_data;
  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_rready(inst_rready),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .data_rready(data_rready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Synchronous SRAM: read-first, output garbage when not enabled.
  always @(posedge clk) begin
    if (bd_en) begin
      mem[bd_addr[11:2]] <= bd_data;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr[11:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
    if (sram_en) sram_rdata <= mem[sram_addr[11:2]];
    else         sram_rdata <= 32'hdead_beef;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_en = 1'b1;
    next_cycle();
    bd_en = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1c00_0000;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf; data_addr = 32'h0000_0100;
    data_wdata = 32'hffff_ffff;
    preload(32'h1c00_0000, 32'h0280_0c0c);
    preload(32'h1c00_0004, 32'h3333_4444);
    preload(32'h0000_0200, 32'h1111_2222);
    preload(32'h0000_0100, 32'h1234_5678);
    @(negedge clk);
    if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin
      $display("FAIL rst_addr_ok act=%b exp=00", {inst_addr_ok, data_addr_ok}); n_fail++; end
    n_cmp++;
    if ({sram_en, sram_we, sram_addr, sram_wdata} !== 69'd0) begin
      $display("FAIL rst_sram act=%b/%h/%h/%h exp=0", sram_en, sram_we, sram_addr, sram_wdata); n_fail++; end
    n_cmp++;
    if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== 66'd0) begin
      $display("FAIL rst_resp act=%b%b/%h/%h exp=0", inst_data_ok, data_data_ok, inst_rdata, data_rdata); n_fail++; end
    n_cmp++;
    next_cycle();
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    if ({sram_en, inst_data_ok, data_data_ok} !== 3'b000) begin
      $display("FAIL rst_idle act=%b exp=000", {sram_en, inst_data_ok, data_data_ok}); n_fail++; end
    n_cmp++;
    next_cycle();
  endtask

  task automatic test_inst_read;
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; inst_rready = 1'b1;
    @(negedge clk);
    if ({inst_addr_ok, data_addr_ok, sram_en, sram_we} !== 7'b1010000) begin
      $display("FAIL ird_grant act=%b exp=1010000", {inst_addr_ok, data_addr_ok, sram_en, sram_we}); n_fail++; end
    n_cmp++;
    if (sram_addr !== 32'h1c00_0000) begin
      $display("FAIL ird_addr act=%h exp=1c000000", sram_addr); n_fail++; end
    n_cmp++;
    next_cycle();
    inst_req = 1'b0;
    @(negedge clk);
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0280_0c0c) begin
      $display("FAIL ird_resp act=%b/%h exp=1/02800c0c", inst_data_ok, inst_rdata); n_fail++; end
    n_cmp++;
    next_cycle();
    @(negedge clk);
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin
      $display("FAIL ird_done act=%b/%h exp=0/0", inst_data_ok, inst_rdata); n_fail++; end
    n_cmp++;
    next_cycle();
  endtask

  task automatic test_contested;
    inst_req = 1'b1; inst_addr = 32'h1c00_0004; inst_rready = 1'b1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0200; data_rready = 1'b1;
    @(negedge clk);
    if ({data_addr_ok, inst_addr_ok} !== 2'b10 || sram_addr !== 32'h0000_0200) begin
      $display("FAIL con_c0 act=%b/%h exp=10/00000200", {data_addr_ok, inst_addr_ok}, sram_addr); n_fail++; end
    n_cmp++;
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    if ({inst_addr_ok, sram_en, data_data_ok} !== 3'b111 || sram_addr !== 32'h1c00_0004) begin
      $display("FAIL con_c1 act=%b/%h exp=111/1c000004", {inst_addr_ok, sram_en, data_data_ok}, sram_addr); n_fail++; end
    n_cmp++;
    if (data_rdata !== 32'h1111_2222) begin
      $display("FAIL con_drdata act=%h exp=11112222", data_rdata); n_fail++; end
    n_cmp++;
    next_cycle();
    inst_req = 1'b0;
    @(negedge clk);
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3333_4444 || data_data_ok !== 1'b0) begin
      $display("FAIL con_c2 act=%b/%h/%b exp=1/33334444/0", inst_data_ok, inst_rdata, data_data_ok); n_fail++; end
    n_cmp++;
    next_cycle();
  endtask

  task automatic test_starve;
    inst_req = 1'b1; inst_addr = 32'h1c00_0008; inst_rready = 1'b1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0300; data_rready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (data_addr_ok !== (c < 4) || inst_addr_ok !== (c == 4)) begin
        $display("FAIL stv_grant c=%0d act=d%b/i%b exp=d%b/i%b", c, data_addr_ok, inst_addr_ok, c < 4, c == 4); n_fail++; end
      n_cmp++;
      if (c > 0) begin
        if (data_data_ok !== 1'b1) begin
          $display("FAIL stv_dok c=%0d act=%b exp=1", c, data_data_ok); n_fail++; end
        n_cmp++;
      end
      next_cycle();
    end
    // inst keeps requesting: a fresh contested cycle with the counter cleared
    @(negedge clk);
    if (dut.starve_q !== 3'd0) begin
      $display("FAIL stv_cnt act=%0d exp=0", dut.starve_q); n_fail++; end
    n_cmp++;
    if ({inst_data_ok, data_addr_ok, inst_addr_ok} !== 3'b110) begin
      $display("FAIL stv_c5 act=%b exp=110", {inst_data_ok, data_addr_ok, inst_addr_ok}); n_fail++; end
    n_cmp++;
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    if ({data_data_ok, inst_addr_ok} !== 2'b11) begin
      $display("FAIL stv_c6 act=%b exp=11", {data_data_ok, inst_addr_ok}); n_fail++; end
    n_cmp++;
    next_cycle();
    inst_req = 1'b0;
    @(negedge clk);
    if (inst_data_ok !== 1'b1) begin
      $display("FAIL stv_c7 act=%b exp=1", inst_data_ok); n_fail++; end
    n_cmp++;
    next_cycle();
  endtask

  task automatic test_hold;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0200; data_rready = 1'b0;
    @(negedge clk);
    if (data_addr_ok !== 1'b1) begin
      $display("FAIL hld_grant act=%b exp=1", data_addr_ok); n_fail++; end
    n_cmp++;
    next_cycle();
    data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; inst_rready = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      if (data_data_ok !== 1'b1 || data_rdata !== 32'h1111_2222) begin
        $display("FAIL hld_resp c=%0d act=%b/%h exp=1/11112222", c, data_data_ok, data_rdata); n_fail++; end
      n_cmp++;
      if ({sram_en, inst_addr_ok} !== 2'b00) begin
        $display("FAIL hld_block c=%0d act=%b exp=00", c, {sram_en, inst_addr_ok}); n_fail++; end
      n_cmp++;
      next_cycle();
    end
    data_rready = 1'b1;
    @(negedge clk);
    if ({data_data_ok, inst_addr_ok, sram_en} !== 3'b111 || data_rdata !== 32'h1111_2222) begin
      $display("FAIL hld_rel act=%b/%h exp=111/11112222", {data_data_ok, inst_addr_ok, sram_en}, data_rdata); n_fail++; end
    n_cmp++;
    next_cycle();
    inst_req = 1'b0;
    @(negedge clk);
    if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h0280_0c0c) begin
      $display("FAIL hld_inst act=%b/%h exp=10/02800c0c", {inst_data_ok, data_data_ok}, inst_rdata); n_fail++; end
    n_cmp++;
    next_cycle();
  endtask

  task automatic test_write;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_rready = 1'b1;
    data_addr = 32'h0000_0100; data_wdata = 32'haabb_ccdd;
    @(negedge clk);
    if ({data_addr_ok, sram_en, sram_we} !== 6'b110011 || sram_wdata !== 32'haabb_ccdd) begin
      $display("FAIL wr_grant act=%b/%h exp=110011/aabbccdd", {data_addr_ok, sram_en, sram_we}, sram_wdata); n_fail++; end
    n_cmp++;
    next_cycle();
    data_wr = 1'b0; data_wstrb = 4'b0000; data_wdata = 32'h0;
    @(negedge clk);
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h0) begin
      $display("FAIL wr_resp act=%b/%h exp=1/00000000", data_data_ok, data_rdata); n_fail++; end
    n_cmp++;
    if ({data_addr_ok, sram_we} !== 5'b10000) begin
      $display("FAIL wr_rdgrant act=%b exp=10000", {data_addr_ok, sram_we}); n_fail++; end
    n_cmp++;
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h1234_ccdd) begin
      $display("FAIL wr_readback act=%b/%h exp=1/1234ccdd", data_data_ok, data_rdata); n_fail++; end
    n_cmp++;
    next_cycle();
  endtask

  task automatic test_reset_mid;
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; inst_rready = 1'b1;
    next_cycle();
    inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0200; data_rready = 1'b1;
    resetn = 1'b0;
    @(negedge clk);
    if ({inst_data_ok, inst_rdata, data_addr_ok, sram_en} !== 35'd0) begin
      $display("FAIL mrst_out act=%b/%h/%b/%b exp=0", inst_data_ok, inst_rdata, data_addr_ok, sram_en); n_fail++; end
    n_cmp++;
    next_cycle();
    data_req = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    if ({inst_data_ok, data_data_ok, sram_en} !== 3'b000) begin
      $display("FAIL mrst_idle act=%b exp=000", {inst_data_ok, data_data_ok, sram_en}); n_fail++; end
    n_cmp++;
    next_cycle();
    data_req = 1'b1;
    @(negedge clk);
    if (data_addr_ok !== 1'b1) begin
      $display("FAIL mrst_grant act=%b exp=1", data_addr_ok); n_fail++; end
    n_cmp++;
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h1111_2222) begin
      $display("FAIL mrst_resp act=%b/%h exp=1/11112222", data_data_ok, data_rdata); n_fail++; end
    n_cmp++;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; bd_en = 1'b0; bd_addr = 32'h0; bd_data = 32'h0;
    inst_req = 1'b0; inst_addr = 32'h0; inst_rready = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0;
    data_wdata = 32'h0; data_rready = 1'b0;
    next_cycle();
    test_reset();
    test_inst_read();
    test_contested();
    test_starve();
    test_hold();
    test_write();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
